tail_light_sequencer: RTL
=========================

TAIL_LIGHT_SEQUENCER -- requirements
Module: tail_light_sequencer

Interface
REQ-001 Parameter: STEP_EXP, 22, step period = 2^STEP_EXP fst_clk cycles.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth on every request input, min 2.
REQ-003 Port: fst_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: left  input  1  left turn request, asynchronous level.
REQ-006 Port: right  input  1  right turn request, asynchronous level.
REQ-007 Port: hazard  input  1  hazard request, asynchronous level.
REQ-008 Port: brake  input  1  brake request, asynchronous level.
REQ-009 Port: run_en  input  1  running-light enable, asynchronous level.
REQ-010 Port: lamp_on  output  6  per-lamp enable to downstream dimmer; [0..2]=R1..R3 (inner->outer), [3..5]=L1..L3.
REQ-011 Port: lamp_level  output  12  2 bits per lamp, same order; 0/1/2/3 = 20/40/60/80 % duty.
REQ-012 Port: seq_active  output  1  high whenever state is not IDLE.

Function
REQ-013 Request inputs SHALL pass through SYNC_STAGES flops before use; no other logic sees raw inputs.
REQ-014 A free-running counter of STEP_EXP bits SHALL produce a one-cycle step tick when it wraps from all-ones to zero.
REQ-015 The FSM SHALL use states IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON, HAZ_OFF and change state only in a tick cycle.
REQ-016 Request decode, priority order: hazard, or left and right together -> HAZ; else left -> LEFT; else right -> RIGHT; else NONE.
REQ-017 From IDLE on tick: HAZ -> HAZ_ON; LEFT -> L1; RIGHT -> R1; NONE -> IDLE.
REQ-018 LEFT held: L1 -> L2 -> L3 -> IDLE -> L1 on successive ticks; RIGHT mirrors with R1..R3.
REQ-019 In any Lx/Rx state, a tick with a decode other than the current direction SHALL go to IDLE; the new request starts on the following tick.
REQ-020 HAZ_ON <-> HAZ_OFF SHALL alternate each tick while HAZ holds; any other decode on a tick -> IDLE.
REQ-021 Sequenced lamps: Lk/Rk state lights inner lamps 1..k of that side, each at level 3.
REQ-022 HAZ_ON SHALL light all six lamps at level 3; HAZ_OFF all six off; brake and run_en are ignored in both hazard states.
REQ-023 Lamps not claimed by a sequence (other side, or all in IDLE): synced brake -> on, level 3; else synced run_en -> on, level 0; else off, level 0.
REQ-024 Lamps of the sequencing side not lit by the current step SHALL be off with level 0, regardless of brake or run_en.
REQ-025 lamp_on, lamp_level and seq_active SHALL be registered: the value reflects the state and synced inputs of the previous cycle.
REQ-026 Worst-case turn-on latency: SYNC_STAGES + 2^STEP_EXP + 1 cycles from request edge to first lamp_on change.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state IDLE, counter 0, synchronizers 0, lamp_on 0, lamp_level 0, seq_active 0.
REQ-028 Reset mid-sequence SHALL abandon the sequence; after release the first tick occurs 2^STEP_EXP cycles later.

Structure
REQ-029 Shared package tail_light_pkg SHALL hold the state enum, level constants LVL_20..LVL_80, and lamp index constants.
REQ-030 Step counter and tick SHALL be one sub-module, step_tick_gen, parameterised by STEP_EXP; synchronizers stay inline.

Verification (STEP_EXP=4, SYNC_STAGES=2)
REQ-031 Hold left from reset release: lamp_on = 001000, 011000, 111000, 000000, repeat every 16 cycles; seq_active drops in IDLE only.
REQ-032 Assert left and right together: lamp_on alternates 111111 / 000000 each 16 cycles, all levels 3; brake toggling has no effect.
REQ-033 Right sequencing at R2 with brake=1: lamp_on = 111011, left-lamp levels 3, R3 level 0.
REQ-034 Idle with run_en=1, brake=0: lamp_on = 111111, lamp_level = all 0; raising brake -> all levels 3 within 3 cycles.
REQ-035 Switch left -> right while in L2: next tick IDLE (000000), following tick R1 (000001).
REQ-036 Pulse rst_n low for 1 cycle while in HAZ_ON: outputs zero in that cycle, no lamp change for 16 cycles after release.

Source files
------------

// File: rtl/tail_light_pkg.sv
// tail_light_pkg -- shared definitions for the tail-light sequencer.
//   state_t      : sequencer FSM states
//   req_t        : decoded request after priority resolution
//   LVL_20..80   : 2-bit duty codes sent to the downstream dimmer
//   LAMP_*       : bit positions of each lamp in lamp_on / lamp_level
//   decode_req() : priority decode of the synchronised request lines
package tail_light_pkg;

  typedef enum logic [3:0] {
    IDLE,
    L1,
    L2,
    L3,
    R1,
    R2,
    R3,
    HAZ_ON,
    HAZ_OFF
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_LEFT,
    REQ_RIGHT,
    REQ_HAZ
  } req_t;

  localparam logic [1:0] LVL_20 = 2'd0;
  localparam logic [1:0] LVL_40 = 2'd1;
  localparam logic [1:0] LVL_60 = 2'd2;
  localparam logic [1:0] LVL_80 = 2'd3;

  // Right lamps occupy the low half, left lamps the high half; within each
  // side the index runs inner -> outer.
  localparam int LAMP_R1   = 0;
  localparam int LAMP_R2   = 1;
  localparam int LAMP_R3   = 2;
  localparam int LAMP_L1   = 3;
  localparam int LAMP_L2   = 4;
  localparam int LAMP_L3   = 5;
  localparam int NUM_LAMPS = 6;
  localparam int SIDE_LAMPS = 3;

  // Both turn requests at once is treated as a hazard request.
  function automatic req_t decode_req(input logic left_s, input logic right_s,
                                      input logic hazard_s);
    if (hazard_s || (left_s && right_s)) return REQ_HAZ;
    else if (left_s)                     return REQ_LEFT;
    else if (right_s)                    return REQ_RIGHT;
    else                                 return REQ_NONE;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen -- free-running step timer.
//   fst_clk : clock
//   rst_n   : asynchronous active-low reset, clears the counter
//   tick    : high for the one cycle in which the counter wraps from
//             all-ones back to zero (once every 2^STEP_EXP cycles)
module step_tick_gen #(
  parameter int STEP_EXP = 22
) (
  input  logic fst_clk,
  input  logic rst_n,
  output logic tick
);

  logic [STEP_EXP-1:0] count_reg;

  always_ff @(posedge fst_clk or negedge rst_n) begin
    if (!rst_n) count_reg <= '0;
    else        count_reg <= count_reg + 1'b1;
  end

  // Combinational so the FSM moves on the same edge that wraps the counter.
  assign tick = &count_reg;

endmodule

// File: rtl/tail_light_sequencer.sv
// tail_light_sequencer -- sequential turn / hazard / brake tail-light driver.
//   fst_clk    : single clock
//   rst_n      : asynchronous active-low reset
//   left, right, hazard, brake, run_en : asynchronous request levels
//   lamp_on    : per-lamp enable, [2:0]=R1..R3, [5:3]=L1..L3 (inner->outer)
//   lamp_level : 2 bits per lamp in the same order, 0..3 = 20..80 % duty
//   seq_active : high whenever the FSM is not IDLE
// Outputs are registered and reflect the state and synchronised inputs of
// the previous cycle.
module tail_light_sequencer
  import tail_light_pkg::*;
#(
  parameter int STEP_EXP    = 22,
  parameter int SYNC_STAGES = 2
) (
  input  logic        fst_clk,
  input  logic        rst_n,
  input  logic        left,
  input  logic        right,
  input  logic        hazard,
  input  logic        brake,
  input  logic        run_en,
  output logic [5:0]  lamp_on,
  output logic [11:0] lamp_level,
  output logic        seq_active
);

  // Synchronizer chain; stage 0 samples the raw pins, the last stage is the
  // only view of the requests the rest of the logic gets.
  localparam int NREQ = 5;
  logic [NREQ-1:0] raw_req;
  logic [SYNC_STAGES-1:0][NREQ-1:0] sync_reg;
  logic left_s, right_s, hazard_s, brake_s, run_s;

  assign raw_req = {run_en, brake, hazard, right, left};

  always_ff @(posedge fst_clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_req};
  end

  assign {run_s, brake_s, hazard_s, right_s, left_s} = sync_reg[SYNC_STAGES-1];

  logic tick;

  step_tick_gen #(
    .STEP_EXP (STEP_EXP)
  ) u_step_tick_gen (
    .fst_clk (fst_clk),
    .rst_n   (rst_n),
    .tick    (tick)
  );

  state_t state_reg, state_next;
  req_t   req;

  assign req = decode_req(left_s, right_s, hazard_s);

  always_ff @(posedge fst_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A changed request during a sequence always passes through IDLE first,
  // so the new pattern starts one tick later.
  always_comb begin
    state_next = state_reg;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          case (req)
            REQ_HAZ:   state_next = HAZ_ON;
            REQ_LEFT:  state_next = L1;
            REQ_RIGHT: state_next = R1;
            default:   state_next = IDLE;
          endcase
        end
        L1:      state_next = (req == REQ_LEFT)  ? L2 : IDLE;
        L2:      state_next = (req == REQ_LEFT)  ? L3 : IDLE;
        R1:      state_next = (req == REQ_RIGHT) ? R2 : IDLE;
        R2:      state_next = (req == REQ_RIGHT) ? R3 : IDLE;
        HAZ_ON:  state_next = (req == REQ_HAZ)   ? HAZ_OFF : IDLE;
        HAZ_OFF: state_next = (req == REQ_HAZ)   ? HAZ_ON  : IDLE;
        default: state_next = IDLE;  // L3 / R3 end the sweep
      endcase
    end
  end

  // Output decode: start every lamp at its brake/run value, then let the
  // active sequence overwrite the side it owns.
  logic [5:0]  lamp_on_next;
  logic [11:0] lamp_level_next;
  logic [1:0]  step_cnt;
  logic        seq_left, seq_right;

  always_comb begin
    lamp_on_next    = '0;
    lamp_level_next = '0;
    step_cnt        = 2'd0;
    seq_left        = 1'b0;
    seq_right       = 1'b0;

    for (int i = 0; i < NUM_LAMPS; i++) begin
      if (brake_s) begin
        lamp_on_next[i]         = 1'b1;
        lamp_level_next[2*i +: 2] = LVL_80;
      end else if (run_s) begin
        lamp_on_next[i]         = 1'b1;
        lamp_level_next[2*i +: 2] = LVL_20;
      end
    end

    case (state_reg)
      L1: begin seq_left  = 1'b1; step_cnt = 2'd1; end
      L2: begin seq_left  = 1'b1; step_cnt = 2'd2; end
      L3: begin seq_left  = 1'b1; step_cnt = 2'd3; end
      R1: begin seq_right = 1'b1; step_cnt = 2'd1; end
      R2: begin seq_right = 1'b1; step_cnt = 2'd2; end
      R3: begin seq_right = 1'b1; step_cnt = 2'd3; end
      HAZ_ON: begin
        lamp_on_next    = '1;
        lamp_level_next = {NUM_LAMPS{LVL_80}};
      end
      HAZ_OFF: begin
        lamp_on_next    = '0;
        lamp_level_next = '0;
      end
      default: ;
    endcase

    // Unlit lamps on the sequencing side are dark even under brake/run.
    for (int i = 0; i < SIDE_LAMPS; i++) begin
      if (seq_left) begin
        lamp_on_next[LAMP_L1 + i]             = (i < int'(step_cnt));
        lamp_level_next[2*(LAMP_L1 + i) +: 2] = (i < int'(step_cnt)) ? LVL_80 : LVL_20;
      end
      if (seq_right) begin
        lamp_on_next[LAMP_R1 + i]             = (i < int'(step_cnt));
        lamp_level_next[2*(LAMP_R1 + i) +: 2] = (i < int'(step_cnt)) ? LVL_80 : LVL_20;
      end
    end
  end

  always_ff @(posedge fst_clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_on    <= '0;
      lamp_level <= '0;
      seq_active <= 1'b0;
    end else begin
      lamp_on    <= lamp_on_next;
      lamp_level <= lamp_level_next;
      seq_active <= (state_reg != IDLE);
    end
  end

endmodule
